// File: rtl/in_flight_return_buffer.sv
// In-flight return buffer: one RAM split into COLORS fixed partitions. Each
// partition is an independent FIFO, drained in order on request.
// Every drained entry produces a one-cycle retire pulse carrying its tag. That
// pulse feeds the tracker's pop/pop_tag and closes the credit loop.
// Handshake: there is no ready. wr_en/rd_en are requests accepted on the edge
// only when the partition has room / holds data (pre-edge state). rd_valid is
// a one-cycle qualifier for rd_data, asserted exactly one cycle after the
// accepting edge; the consumer must take it in that cycle.
module in_flight_return_buffer #(
  parameter int COLORS          = 4,
  parameter int DEPTH_PER_COLOR = 128,
  parameter int WIDTH           = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(COLORS)-1:0] wr_tag,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [$clog2(COLORS)-1:0] rd_tag,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      retire,
  output logic [$clog2(COLORS)-1:0] retire_tag,
  output logic [COLORS-1:0]         empty,
  output logic                      overflow
);

  localparam int TAG_W  = $clog2(COLORS);
  localparam int PTR_W  = $clog2(DEPTH_PER_COLOR);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ADDR_W = TAG_W + PTR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH_PER_COLOR);

  logic [WIDTH-1:0] mem_q [COLORS*DEPTH_PER_COLOR];

  logic [PTR_W-1:0] wptr_q  [COLORS];
  logic [PTR_W-1:0] wptr_d  [COLORS];
  logic [PTR_W-1:0] rptr_q  [COLORS];
  logic [PTR_W-1:0] rptr_d  [COLORS];
  logic [CNT_W-1:0] count_q [COLORS];
  logic [CNT_W-1:0] count_d [COLORS];

  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [TAG_W-1:0] retire_tag_q, retire_tag_d;
  logic             overflow_q, overflow_d;

  logic              wr_full;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [COLORS-1:0] wr_sel;
  logic [COLORS-1:0] rd_sel;

  // Acceptance decisions and RAM addresses, all from pre-edge state (no bypass).
  always_comb begin
    wr_full = (count_q[wr_tag] == FULL_CNT);
    wr_acc  = wr_en && !wr_full;
    rd_acc  = rd_en && (count_q[rd_tag] != '0);
    wr_addr = {wr_tag, wptr_q[wr_tag]};
    rd_addr = {rd_tag, rptr_q[rd_tag]};
    wr_sel  = '0;
    rd_sel  = '0;
    if (wr_acc) wr_sel = {{(COLORS-1){1'b0}}, 1'b1} << wr_tag;
    if (rd_acc) rd_sel = {{(COLORS-1){1'b0}}, 1'b1} << rd_tag;
  end

  // Per-partition pointer and occupancy updates; a same-tag write+read leaves count unchanged.
  always_comb begin
    for (int i = 0; i < COLORS; i++) begin
      wptr_d[i]  = wptr_q[i] + PTR_W'(wr_sel[i]);
      rptr_d[i]  = rptr_q[i] + PTR_W'(rd_sel[i]);
      count_d[i] = count_q[i];
      if (wr_sel[i] && !rd_sel[i]) count_d[i] = count_q[i] + 1'b1;
      else if (!wr_sel[i] && rd_sel[i]) count_d[i] = count_q[i] - 1'b1;
    end
  end

  // Next values of the registered read/retire outputs and the sticky overflow flag.
  always_comb begin
    rd_valid_d   = rd_acc;
    rd_data_d    = rd_acc ? mem_q[rd_addr] : rd_data_q;
    retire_tag_d = rd_acc ? rd_tag : retire_tag_q;
    overflow_d   = overflow_q | (wr_en && wr_full);
  end

  // Payload storage; contents are meaningless until pointers say otherwise, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_addr] <= wr_data;
  end

  // Control state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COLORS; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      retire_tag_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      for (int i = 0; i < COLORS; i++) begin
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        count_q[i] <= count_d[i];
      end
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      retire_tag_q <= retire_tag_d;
      overflow_q   <= overflow_d;
    end
  end

  // Empty flags follow the registered counts, so they show post-edge occupancy.
  always_comb begin
    empty = '0;
    for (int i = 0; i < COLORS; i++) empty[i] = (count_q[i] == '0);
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign retire     = rd_valid_q;
  assign retire_tag = retire_tag_q;
  assign overflow   = overflow_q;

`ifndef SYNTHESIS
  // Dropped writes mean the credit loop upstream is broken; make them loud in simulation.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && wr_full)
      $warning("in_flight_return_buffer: write to full partition %0d dropped", wr_tag);
  end
`endif

endmodule
